// File: rtl/lsq_pkg.sv
// Shared types for the L1 load/store queue: entry states, entry record and
// the default field widths used by the queue and its entry storage.
package lsq_pkg;

  localparam int LSQ_ADDR_WIDTH = 32;
  localparam int LSQ_DATA_WIDTH = 32;
  localparam int LSQ_TAG_WIDTH  = 5;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND   = 2'd1,
    ISSUED = 2'd2,
    DONE   = 2'd3
  } lsq_state_e;

  typedef struct packed {
    lsq_state_e                state;
    logic                      rw;
    logic [LSQ_ADDR_WIDTH-1:0] addr;
    logic [LSQ_DATA_WIDTH-1:0] data;
    logic [LSQ_TAG_WIDTH-1:0]  tag;
  } lsq_entry_t;

  // Build a freshly allocated entry, waiting to be issued to the L1.
  function automatic lsq_entry_t lsq_make_entry(
    input logic                      rw,
    input logic [LSQ_ADDR_WIDTH-1:0] addr,
    input logic [LSQ_DATA_WIDTH-1:0] data,
    input logic [LSQ_TAG_WIDTH-1:0]  tag
  );
    lsq_entry_t e;
    e.state = PEND;
    e.rw    = rw;
    e.addr  = addr;
    e.data  = data;
    e.tag   = tag;
    return e;
  endfunction

endpackage

// File: rtl/lsq_entry_file.sv
// Entry storage for the load/store queue. One write port for allocation, one
// for L1 load responses (only accepted by an ISSUED entry), state-only updates
// for issue and retire, and two asynchronous read ports (issue and head).
module lsq_entry_file
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_en,
  input  logic [IDX_W-1:0]          alloc_idx,
  input  lsq_entry_t                alloc_entry,
  input  logic                      rsp_en,
  input  logic [IDX_W-1:0]          rsp_idx,
  input  logic [LSQ_DATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_hit,
  input  logic [IDX_W-1:0]          issue_idx,
  input  logic                      issue_en,
  output lsq_entry_t                issue_entry,
  input  logic [IDX_W-1:0]          head_idx,
  input  logic                      retire_en,
  output lsq_entry_t                head_entry
);

  lsq_entry_t [DEPTH-1:0] entry_vec;

  // A response is only meaningful for an outstanding load; anything else is dropped.
  assign rsp_hit     = rsp_en && (entry_vec[rsp_idx].state == ISSUED);
  assign issue_entry = entry_vec[issue_idx];
  assign head_entry  = entry_vec[head_idx];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      lsq_entry_t entry_reg;
      lsq_entry_t entry_next;

      // Next value of this entry from the alloc, issue, response and retire ports.
      always_comb begin
        entry_next = entry_reg;
        if (alloc_en && (alloc_idx == IDX_W'(gi))) begin
          entry_next = alloc_entry;
        end
        if (issue_en && (issue_idx == IDX_W'(gi))) begin
          // Stores complete on L1 acceptance; loads wait for their data.
          entry_next.state = entry_reg.rw ? DONE : ISSUED;
        end
        if (rsp_hit && (rsp_idx == IDX_W'(gi))) begin
          entry_next.state = DONE;
          entry_next.data  = rsp_data;
        end
        if (retire_en && (head_idx == IDX_W'(gi))) begin
          entry_next.state = FREE;
        end
      end

      // Entry register; reset leaves every slot FREE with cleared fields.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else begin
          entry_reg <= entry_next;
        end
      end

      assign entry_vec[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/l1_ldst_queue.sv
// Core-side load/store queue in front of the L1 data cache. Ops are issued
// in program order (queue index = L1 id), load data returns out of order and
// results retire to the core in program order.
// Optional build macro LSQ_STATS_EN adds saturating issue/stall counters.
module l1_ldst_queue
  import lsq_pkg::*;
#(
  parameter int ADDR_WIDTH    = LSQ_ADDR_WIDTH,
  parameter int DATA_WIDTH    = LSQ_DATA_WIDTH,
  parameter int DEPTH         = 8,
  parameter int L1_ID_BITS    = 4,
  parameter int CORE_TAG_BITS = LSQ_TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic [CORE_TAG_BITS-1:0] req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_rw,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [CORE_TAG_BITS-1:0] resp_tag,
  output logic                     l1_valid_o,
  output logic                     l1_rw_o,
  output logic [ADDR_WIDTH-1:0]    l1_addr_o,
  output logic [DATA_WIDTH-1:0]    l1_data_o,
  output logic [L1_ID_BITS-1:0]    l1_id_o,
  input  logic                     l1_stall_i,
  input  logic                     l1_ready_i,
  input  logic [L1_ID_BITS-1:0]    l1_id_i,
  input  logic [DATA_WIDTH-1:0]    l1_data_i,
  output logic                     err_o
`ifdef LSQ_STATS_EN
  ,
  output logic [31:0]              stat_ld_o,
  output logic [31:0]              stat_st_o,
  output logic [31:0]              stat_stall_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] alloc_ptr_reg, alloc_ptr_next;
  logic [IDX_W-1:0] issue_ptr_reg, issue_ptr_next;
  logic [IDX_W-1:0] head_ptr_reg,  head_ptr_next;
  logic [IDX_W:0]   count_reg,     count_next;
  logic             err_reg;

  lsq_entry_t alloc_entry;
  lsq_entry_t issue_entry;
  lsq_entry_t head_entry;
  logic       rsp_hit;
  logic       alloc_fire;
  logic       issue_fire;
  logic       retire_fire;
  logic       fields_unused;

  // Full check uses registered count only: a same-cycle retire never frees a slot early.
  assign req_ready   = (count_reg != FULL_COUNT);
  assign alloc_fire  = req_valid && req_ready;
  assign alloc_entry = lsq_make_entry(req_rw, req_addr, req_data, req_tag);

  assign l1_valid_o  = (issue_entry.state == PEND);
  assign issue_fire  = l1_valid_o && !l1_stall_i;
  assign l1_rw_o     = l1_valid_o ? issue_entry.rw   : 1'b0;
  assign l1_addr_o   = l1_valid_o ? issue_entry.addr : '0;
  assign l1_data_o   = l1_valid_o ? issue_entry.data : '0;
  assign l1_id_o     = l1_valid_o ? L1_ID_BITS'(issue_ptr_reg) : '0;

  assign resp_valid  = (head_entry.state == DONE);
  assign retire_fire = resp_valid && resp_ready;
  assign resp_rw     = resp_valid ? head_entry.rw  : 1'b0;
  assign resp_tag    = resp_valid ? head_entry.tag : '0;
  assign resp_data   = (resp_valid && !head_entry.rw) ? head_entry.data : '0;

  assign err_o       = err_reg;

  // Upper id bits beyond the entry index and unused entry fields are intentionally ignored.
  assign fields_unused = ^{l1_id_i, head_entry.addr, issue_entry.tag};

  lsq_entry_file #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_entry_file (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (alloc_fire),
    .alloc_idx   (alloc_ptr_reg),
    .alloc_entry (alloc_entry),
    .rsp_en      (l1_ready_i),
    .rsp_idx     (l1_id_i[IDX_W-1:0]),
    .rsp_data    (l1_data_i),
    .rsp_hit     (rsp_hit),
    .issue_idx   (issue_ptr_reg),
    .issue_en    (issue_fire),
    .issue_entry (issue_entry),
    .head_idx    (head_ptr_reg),
    .retire_en   (retire_fire),
    .head_entry  (head_entry)
  );

  // Pointer and occupancy update; all pointers wrap modulo DEPTH.
  always_comb begin
    alloc_ptr_next = alloc_ptr_reg;
    issue_ptr_next = issue_ptr_reg;
    head_ptr_next  = head_ptr_reg;
    count_next     = count_reg;
    if (alloc_fire)  alloc_ptr_next = alloc_ptr_reg + IDX_W'(1);
    if (issue_fire)  issue_ptr_next = issue_ptr_reg + IDX_W'(1);
    if (retire_fire) head_ptr_next  = head_ptr_reg + IDX_W'(1);
    case ({alloc_fire, retire_fire})
      2'b10:   count_next = count_reg + (IDX_W+1)'(1);
      2'b01:   count_next = count_reg - (IDX_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer/count registers and the sticky error flag for unexpected L1 responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr_reg <= '0;
      issue_ptr_reg <= '0;
      head_ptr_reg  <= '0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      alloc_ptr_reg <= alloc_ptr_next;
      issue_ptr_reg <= issue_ptr_next;
      head_ptr_reg  <= head_ptr_next;
      count_reg     <= count_next;
      if (l1_ready_i && !rsp_hit) err_reg <= 1'b1;
    end
  end

`ifdef LSQ_STATS_EN
  logic [31:0] stat_ld_reg, stat_st_reg, stat_stall_reg;

  // Saturating counters: loads/stores accepted by the L1 and stalled issue cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ld_reg    <= '0;
      stat_st_reg    <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (issue_fire && !issue_entry.rw && (stat_ld_reg != '1)) stat_ld_reg <= stat_ld_reg + 32'd1;
      if (issue_fire && issue_entry.rw && (stat_st_reg != '1))  stat_st_reg <= stat_st_reg + 32'd1;
      if (l1_valid_o && l1_stall_i && (stat_stall_reg != '1))   stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_ld_o    = stat_ld_reg;
  assign stat_st_o    = stat_st_reg;
  assign stat_stall_o = stat_stall_reg;
`endif

endmodule

// File: tb/tb_l1_ldst_queue.sv
// Scoreboard bench for l1_ldst_queue: allocations push expected issue and
// retire records; an L1 responder model answers loads in a chosen order.
// Build with LSQ_STATS_EN to also compare the statistics counters.
module tb_l1_ldst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw;
  logic [31:0] req_addr, req_data;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready, resp_rw;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        l1_valid_o, l1_rw_o;
  logic [31:0] l1_addr_o, l1_data_o;
  logic [3:0]  l1_id_o;
  logic        l1_stall_i, l1_ready_i;
  logic [3:0]  l1_id_i;
  logic [31:0] l1_data_i;
  logic        err_o;
`ifdef LSQ_STATS_EN
  logic [31:0] stat_ld_o, stat_st_o, stat_stall_o;
`endif

  always #5 clk = ~clk;

  l1_ldst_queue dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rw(resp_rw),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .l1_valid_o(l1_valid_o), .l1_rw_o(l1_rw_o), .l1_addr_o(l1_addr_o),
    .l1_data_o(l1_data_o), .l1_id_o(l1_id_o), .l1_stall_i(l1_stall_i),
    .l1_ready_i(l1_ready_i), .l1_id_i(l1_id_i), .l1_data_i(l1_data_i),
    .err_o(err_o)
`ifdef LSQ_STATS_EN
    , .stat_ld_o(stat_ld_o), .stat_st_o(stat_st_o), .stat_stall_o(stat_stall_o)
`endif
  );

  typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; logic [4:0] tag; } op_t;
  typedef struct { int id; logic [31:0] addr; } pend_t;

  op_t   iss_q[$];
  op_t   sb_q[$];
  pend_t pend_q[$];
  logic [31:0] ld_mem [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_issue_id = 0;
  int m_ld = 0, m_st = 0, m_stall = 0;
  int rsp_mode = 0;
  logic rsp_hold = 1'b0;
  logic stall_force = 1'b0;
  logic rand_stall_en = 1'b0;
  logic rand_stall_bit = 1'b0;
  int inject_cnt = 0, inject_done = 0;
  logic [3:0] inject_id = 4'd0;

  assign l1_stall_i = stall_force | (rand_stall_en & rand_stall_bit);

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // L1 responder (drives after posedge) and monitor/scoreboard (samples at negedge).
  always begin
    @(posedge clk); #1;
    l1_ready_i = 1'b0; l1_id_i = 4'd0; l1_data_i = 32'd0;
    rand_stall_bit = ($urandom_range(0, 2) == 0);
    if (inject_done != inject_cnt) begin
      inject_done++;
      l1_ready_i = 1'b1; l1_id_i = inject_id; l1_data_i = 32'hBAD0_BAD0;
    end else if (!rsp_hold && pend_q.size() > 0 && (rsp_mode != 2 || $urandom_range(0, 1) == 1)) begin
      int k;
      if (rsp_mode == 0)      k = 0;
      else if (rsp_mode == 1) k = pend_q.size() - 1;
      else                    k = $urandom_range(0, pend_q.size() - 1);
      l1_ready_i = 1'b1;
      l1_id_i    = 4'(pend_q[k].id);
      l1_data_i  = ld_mem[pend_q[k].addr];
      pend_q.delete(k);
    end
    @(negedge clk);
    if (!reset) begin
      iss_q.delete(); sb_q.delete(); pend_q.delete();
      exp_issue_id = 0; m_ld = 0; m_st = 0; m_stall = 0;
    end else begin
      if (l1_valid_o && l1_stall_i) m_stall++;
      if (l1_valid_o && !l1_stall_i) begin
        if (iss_q.size() == 0) begin
          check_value("issue_unexpected", 1, 0);
        end else begin
          op_t op;
          op = iss_q.pop_front();
          check_value("issue_id", l1_id_o, exp_issue_id);
          check_value("issue_rw", l1_rw_o, op.rw);
          check_value("issue_addr", l1_addr_o, op.addr);
          if (op.rw) begin
            check_value("issue_data", l1_data_o, op.data);
            m_st++;
          end else begin
            pend_q.push_back('{id: exp_issue_id, addr: op.addr});
            m_ld++;
          end
          exp_issue_id = (exp_issue_id + 1) % 8;
        end
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          check_value("resp_unexpected", 1, 0);
        end else begin
          op_t e;
          e = sb_q.pop_front();
          check_value("resp_tag", resp_tag, e.tag);
          check_value("resp_rw", resp_rw, e.rw);
          check_value("resp_data", resp_data, e.rw ? 32'd0 : e.data);
          $display("resp tag=%0d rw=%0d data=0x%0h", resp_tag, resp_rw, resp_data);
        end
      end
      if (req_valid && req_ready) begin
        op_t n;
        n.rw = req_rw; n.addr = req_addr; n.tag = req_tag;
        n.data = req_rw ? req_data : ld_mem[req_addr];
        iss_q.push_back(n);
        sb_q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // For loads, data is the value the L1 model will return for that address.
  task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] data, input logic [4:0] tag);
    if (!rw) ld_mem[addr] = data;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = rw ? data : 32'd0; req_tag = tag;
    #1;
    for (int i = 0; i < 300 && !req_ready; i++) begin @(posedge clk); #1; end
    if (!req_ready) check_value("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_tag = 5'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && (sb_q.size() != 0 || pend_q.size() != 0 || iss_q.size() != 0); i++) tick();
    check_value("drain_sb_left", sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_req_ready"}, req_ready, 1);
    check_value({tag, "_resp_valid"}, resp_valid, 0);
    check_value({tag, "_l1_valid"}, l1_valid_o, 0);
    check_value({tag, "_err"}, err_o, 0);
    check_value({tag, "_outs"}, {resp_data, resp_tag, l1_addr_o, l1_data_o, l1_id_o, l1_rw_o, resp_rw}, 0);
`ifdef LSQ_STATS_EN
    check_value({tag, "_stats"}, {stat_ld_o, stat_st_o, stat_stall_o}, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_data = 32'd0;
    req_tag = 5'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b1;
    tick();

    // 1: single store, L1 never stalls
    send(1'b1, 32'h100, 32'hDEAD, 5'd3);
    #1;
    check_value("t1_l1_valid", l1_valid_o, 1);
    check_value("t1_l1_id", l1_id_o, 0);
    check_value("t1_l1_rw", l1_rw_o, 1);
    check_value("t1_l1_addr", l1_addr_o, 32'h100);
    check_value("t1_l1_data", l1_data_o, 32'hDEAD);
    check_value("t1_no_resp_yet", resp_valid, 0);
    tick(); #1;
    check_value("t1_resp_valid", resp_valid, 1);
    check_value("t1_resp_rw", resp_rw, 1);
    check_value("t1_resp_tag", resp_tag, 3);
    check_value("t1_resp_data", resp_data, 0);
    wait_drain();

    // 2: two loads answered youngest-first, retired oldest-first
    rsp_hold = 1'b1;
    send(1'b0, 32'h200, 32'h11, 5'd1);
    send(1'b0, 32'h204, 32'h22, 5'd2);
    repeat (4) tick();
    check_value("t2_both_issued", pend_q.size(), 2);
    check_value("t2_no_resp_before_data", resp_valid, 0);
    rsp_mode = 1; rsp_hold = 1'b0;
    wait_drain();
    rsp_mode = 0;

    // reset between scenarios so entry ids start from 0
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1; #1;
    check_reset_outputs("rst1");
    tick();

    // 3: fill the queue while the L1 stalls, then release and wrap
    stall_force = 1'b1;
    for (int i = 0; i < 8; i++) send(i[0], 32'h300 + 32'(i * 4), 32'hA000 + 32'(i), 5'(i));
    #1;
    check_value("t3_full_ready", req_ready, 0);
    check_value("t3_head_stalled_id", l1_id_o, 0);
    tick();
    stall_force = 1'b0;
    send(1'b0, 32'h340, 32'h9999, 5'd8);
    wait_drain();

    // 4: stall a load for three cycles
    stall_force = 1'b1;
    send(1'b0, 32'h400, 32'h4444, 5'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_value("t4_hold_valid", l1_valid_o, 1);
      check_value("t4_hold_addr", l1_addr_o, 32'h400);
      check_value("t4_hold_id", l1_id_o, 1);
      check_value("t4_hold_rw", l1_rw_o, 0);
      tick();
    end
    stall_force = 1'b0;
    tick(); #1;
    check_value("t4_issued_after_release", l1_valid_o, 0);
`ifdef LSQ_STATS_EN
    check_value("t4_stat_stall", stat_stall_o, m_stall);
`endif
    wait_drain();

    // 5: full queue, head DONE, retire and request in the same cycle
    resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b1, 32'h500 + 32'(i), 32'hB000 + 32'(i), 5'(10 + i));
    repeat (3) tick();
    #1;
    check_value("t5_full", req_ready, 0);
    check_value("t5_head_done", resp_valid, 1);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h600; req_data = 32'hC0DE; req_tag = 5'd20;
    #1;
    check_value("t5_no_same_cycle_alloc", req_ready, 0);
    tick(); #1;
    check_value("t5_slot_free_next", req_ready, 1);
    tick();
    req_valid = 1'b0;
    wait_drain();

    // 6: response for a FREE entry, then reset mid-traffic
    check_value("t6_err_clear", err_o, 0);
    inject_id = 4'd5; inject_cnt++;
    repeat (3) tick();
    #1;
    check_value("t6_err_set", err_o, 1);
    check_value("t6_no_resp", resp_valid, 0);
    check_value("t6_no_issue", l1_valid_o, 0);
    check_value("t6_not_full", req_ready, 1);
    repeat (3) tick();
    check_value("t6_err_sticky", err_o, 1);
    stall_force = 1'b1;
    send(1'b0, 32'h700, 32'h7777, 5'd21);
    send(1'b1, 32'h704, 32'h7070, 5'd22);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    tick(); tick();
    reset = 1'b1; stall_force = 1'b0; #1;
    check_reset_outputs("rst2");
    inject_id = 4'd0; inject_cnt++;
    repeat (3) tick();
    check_value("t6_pre_reset_id_err", err_o, 1);

    // random mix with random stalls and out-of-order responses
    rsp_mode = 2; rand_stall_en = 1'b1;
    for (int i = 0; i < 24; i++) send(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), $urandom, 5'(i));
    rand_stall_en = 1'b0;
    wait_drain();
`ifdef LSQ_STATS_EN
    #1;
    check_value("end_stat_ld", stat_ld_o, m_ld);
    check_value("end_stat_st", stat_st_o, m_st);
    check_value("end_stat_stall", stat_stall_o, m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
